// File: rtl/fetch_pc_unit_if.sv
// Fetch-stage bundle: hazard/branch inputs toward the PC unit and the PC/IF-ID state it reports back.
// The master side belongs to the pipeline control, the slave side to fetch_pc_unit.
interface fetch_pc_unit_if;
   logic        stall;
   logic        BrTaken;
   logic [31:0] pc_br;
   logic [31:0] pc_out;
   logic [31:0] pc_id;
   logic        id_valid;
   logic        flush_if;
   logic [15:0] br_count;

   modport master (
      output stall, BrTaken, pc_br,
      input  pc_out, pc_id, id_valid, flush_if, br_count
   );

   modport slave (
      input  stall, BrTaken, pc_br,
      output pc_out, pc_id, id_valid, flush_if, br_count
   );
endinterface

// File: rtl/fetch_pc_unit.sv
// Program counter, IF/ID PC register and taken-branch counter for a 5-stage fetch.
// Optional macro DELAY_SLOT_EN: the branch shadow instruction executes instead of being squashed.
module fetch_pc_unit (
   input logic             clk,
   input logic             reset,
   fetch_pc_unit_if.slave  bus
);
   localparam logic [31:0] PC_INIT = 32'h0000_0000;

   function automatic logic [15:0] sat_inc16(input logic [15:0] value);
      if (value == 16'hFFFF) begin
         return value;
      end else begin
         return value + 16'd1;
      end
   endfunction

   logic [31:0] pc_r;
   logic [31:0] pc_id_r;
   logic        id_valid_r;
   logic [15:0] br_count_r;
   logic        advance_s;
   logic        redirect_s;
   logic [31:0] pc_next_s;
   logic [15:0] br_count_next_s;
   logic        id_valid_next_s;
   logic        flush_s;
   logic        unused_pc_br_s;

   // Targets are word aligned; the low bits of pc_br carry no information.
   assign unused_pc_br_s = ^bus.pc_br[1:0];

   // Next-PC selection and branch counting; a stall masks BrTaken entirely.
   always_comb begin
      advance_s       = ~bus.stall;
      redirect_s      = advance_s & bus.BrTaken;
      pc_next_s       = pc_r + 32'd4;
      br_count_next_s = br_count_r;
      if (redirect_s) begin
         pc_next_s       = {bus.pc_br[31:2], 2'b00};
         br_count_next_s = sat_inc16(br_count_r);
      end else begin
         pc_next_s       = pc_r + 32'd4;
         br_count_next_s = br_count_r;
      end
   end

`ifdef DELAY_SLOT_EN
   // Shadow slot executes: nothing fetched is ever squashed.
   always_comb begin
      flush_s         = 1'b0;
      id_valid_next_s = 1'b1;
   end
`else
   // Shadow slot is squashed: it enters IF/ID as a bubble on the redirect edge.
   always_comb begin
      flush_s         = redirect_s & ~reset;
      id_valid_next_s = ~redirect_s;
   end
`endif

   // PC and IF/ID state; every register freezes while stalled.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pc_r       <= PC_INIT;
         pc_id_r    <= 32'h0000_0000;
         id_valid_r <= 1'b0;
         br_count_r <= 16'h0000;
      end else if (advance_s) begin
         pc_r       <= pc_next_s;
         pc_id_r    <= pc_r;
         id_valid_r <= id_valid_next_s;
         br_count_r <= br_count_next_s;
      end
   end

   assign bus.pc_out   = pc_r;
   assign bus.pc_id    = pc_id_r;
   assign bus.id_valid = id_valid_r;
   assign bus.br_count = br_count_r;
   assign bus.flush_if = flush_s;
endmodule

// File: tb/tb_fetch_pc_unit.sv
// Scoreboard bench for fetch_pc_unit; expectations come from a behavioural PC model.
module tb_fetch_pc_unit;
   logic clk = 1'b0;
   logic reset;

   always #5 clk = ~clk;

   fetch_pc_unit_if bus ();

   fetch_pc_unit dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

`ifdef DELAY_SLOT_EN
   localparam bit DS = 1'b1;
`else
   localparam bit DS = 1'b0;
`endif

   int          n_tests = 0;
   int          n_fail  = 0;
   logic [80:0] sb[$];
   logic [80:0] e;
   logic [31:0] m_pc;
   logic [31:0] m_pc_id;
   logic        m_valid;
   logic [15:0] m_cnt;
   logic        obs_flush;
   logic        exp_flush;

   wire [80:0] obs = {bus.pc_out, bus.pc_id, bus.id_valid, bus.br_count};

   // One cycle of stimulus: model update, push expectation, advance past the edge.
   task automatic drive(input logic s, input logic b, input logic [31:0] t);
      bus.stall   = s;
      bus.BrTaken = b;
      bus.pc_br   = t;
      #1;
      obs_flush = bus.flush_if;
      exp_flush = b & ~s & ~DS;
      if (!s) begin
         m_pc_id = m_pc;
         m_valid = ~(b & ~DS);
         if (b) begin
            m_pc = {t[31:2], 2'b00};
            if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
         end else begin
            m_pc = m_pc + 32'd4;
         end
      end
      sb.push_back({m_pc, m_pc_id, m_valid, m_cnt});
      @(posedge clk);
      #1;
   endtask

   task automatic apply_reset();
      bus.stall   = 1'b1;
      bus.BrTaken = 1'b0;
      bus.pc_br   = 32'h0;
      reset       = 1'b1;
      #2;
      reset   = 1'b0;
      m_pc    = 32'h0;
      m_pc_id = 32'h0;
      m_valid = 1'b0;
      m_cnt   = 16'h0;
      sb.delete();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      bus.stall   = 1'b0;
      bus.BrTaken = 1'b1;
      bus.pc_br   = 32'h100;
      reset       = 1'b1;
      @(posedge clk);
      #1;
      n_tests++;
      if (obs !== 81'h0) begin
         n_fail++;
         $display("FAIL reset_state: got %h expected %h", obs, 81'h0);
      end
      n_tests++;
      if (bus.flush_if !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_flush: got %b expected 0", bus.flush_if);
      end
      apply_reset();
      n_tests++;
      if (obs !== 81'h0) begin
         n_fail++;
         $display("FAIL reset_stall_hold: got %h expected %h", obs, 81'h0);
      end
   endtask

   task automatic test_sequential();
      for (int i = 0; i < 4; i++) begin
         drive(1'b0, 1'b0, 32'h0);
         e = sb.pop_front();
         n_tests++;
         if (obs !== e) begin
            n_fail++;
            $display("FAIL seq_state[%0d]: got %h expected %h", i, obs, e);
         end
         n_tests++;
         if (bus.pc_out !== 32'(4 * (i + 1)) || bus.id_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL seq_pc[%0d]: got pc %h valid %b expected pc %h valid 1",
                     i, bus.pc_out, bus.id_valid, 32'(4 * (i + 1)));
         end
      end
   endtask

   task automatic test_branch();
      drive(1'b0, 1'b1, 32'h40);
      n_tests++;
      if (obs_flush !== exp_flush) begin
         n_fail++;
         $display("FAIL branch_flush: got %b expected %b", obs_flush, exp_flush);
      end
      e = sb.pop_front();
      n_tests++;
      if (obs !== e) begin
         n_fail++;
         $display("FAIL branch_state: got %h expected %h", obs, e);
      end
      n_tests++;
      if (bus.pc_out !== 32'h40 || bus.pc_id !== 32'h10 || bus.br_count !== 16'd1 || bus.id_valid !== DS) begin
         n_fail++;
         $display("FAIL branch_fields: got pc %h id %h cnt %h valid %b expected 40 10 1 %b",
                  bus.pc_out, bus.pc_id, bus.br_count, bus.id_valid, DS);
      end
   endtask

   task automatic test_stall_branch();
      drive(1'b0, 1'b0, 32'h0);
      e = sb.pop_front();
      n_tests++;
      if (obs !== e) begin
         n_fail++;
         $display("FAIL stall_pre: got %h expected %h", obs, e);
      end
      for (int i = 0; i < 2; i++) begin
         drive(1'b1, 1'b1, 32'h40);
         n_tests++;
         if (obs_flush !== 1'b0) begin
            n_fail++;
            $display("FAIL stall_flush[%0d]: got %b expected 0", i, obs_flush);
         end
         e = sb.pop_front();
         n_tests++;
         if (obs !== e || bus.pc_out !== 32'h44) begin
            n_fail++;
            $display("FAIL stall_hold[%0d]: got %h expected %h", i, obs, e);
         end
      end
      drive(1'b0, 1'b1, 32'h40);
      e = sb.pop_front();
      n_tests++;
      if (obs !== e || bus.pc_out !== 32'h40 || bus.br_count !== 16'd2) begin
         n_fail++;
         $display("FAIL stall_release: got %h expected %h", obs, e);
      end
   endtask

   task automatic test_wrap();
      drive(1'b0, 1'b1, 32'hFFFF_FFFC);
      e = sb.pop_front();
      n_tests++;
      if (obs !== e) begin
         n_fail++;
         $display("FAIL wrap_preload: got %h expected %h", obs, e);
      end
      drive(1'b0, 1'b0, 32'h0);
      e = sb.pop_front();
      n_tests++;
      if (obs !== e || bus.pc_out !== 32'h0) begin
         n_fail++;
         $display("FAIL wrap_zero: got %h expected %h", obs, e);
      end
      drive(1'b0, 1'b1, 32'h43);
      e = sb.pop_front();
      n_tests++;
      if (obs !== e || bus.pc_out !== 32'h40) begin
         n_fail++;
         $display("FAIL align_target: got %h expected %h", obs, e);
      end
   endtask

   task automatic test_saturation();
      apply_reset();
      for (int i = 0; i < 65538; i++) begin
         drive(1'b0, 1'b1, 32'(i * 8));
         e = sb.pop_front();
         n_tests++;
         if (obs !== e) begin
            n_fail++;
            $display("FAIL sat_state[%0d]: got %h expected %h", i, obs, e);
         end
      end
      n_tests++;
      if (bus.br_count !== 16'hFFFF) begin
         n_fail++;
         $display("FAIL sat_hold: got %h expected ffff", bus.br_count);
      end
   endtask

   task automatic test_async_reset();
      bus.stall   = 1'b0;
      bus.BrTaken = 1'b1;
      bus.pc_br   = 32'h200;
      #3;
      reset = 1'b1;
      #1;
      n_tests++;
      if (obs !== 81'h0) begin
         n_fail++;
         $display("FAIL async_reset: got %h expected %h", obs, 81'h0);
      end
      n_tests++;
      if (bus.flush_if !== 1'b0) begin
         n_fail++;
         $display("FAIL async_flush: got %b expected 0", bus.flush_if);
      end
      @(posedge clk);
      #1;
      bus.BrTaken = 1'b0;
      #2;
      reset = 1'b0;
      @(posedge clk);
      #1;
      n_tests++;
      if (obs !== {32'h4, 32'h0, 1'b1, 16'h0}) begin
         n_fail++;
         $display("FAIL post_reset_release: got %h expected %h", obs, {32'h4, 32'h0, 1'b1, 16'h0});
      end
   endtask

   initial begin
      reset       = 1'b0;
      bus.stall   = 1'b1;
      bus.BrTaken = 1'b0;
      bus.pc_br   = 32'h0;
      @(negedge clk);
      test_reset();
      test_sequential();
      test_branch();
      test_stall_branch();
      test_wrap();
      test_saturation();
      test_async_reset();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
